// File: rtl/bram_client_if.sv
// Request/response stream between a CPU-side requester and bram_client.
// The requester drives the master modport; bram_client takes the slave modport.
interface bram_client_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [DATA_WIDTH/8-1:0] req_strobe;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_data;
   logic                    resp_valid;
   logic                    resp_ready;
   logic                    resp_write;
   logic [DATA_WIDTH-1:0]   resp_data;

   modport master (
      output req_valid, req_write, req_strobe, req_addr, req_data, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_data
   );

   modport slave (
      input  req_valid, req_write, req_strobe, req_addr, req_data, resp_ready,
      output req_ready, resp_valid, resp_write, resp_data
   );
endinterface

// File: rtl/bram_client.sv
// Request-side master for one BRAM port (1-cycle read latency, write_first).
// Each accepted request strobes the BRAM; the word returned one cycle later is
// pushed into an in-order response FIFO. Issue credit counts buffered plus
// in-flight responses, so a BRAM result always has a FIFO slot waiting for it.
module bram_client #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int RESP_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   bram_client_if.slave            bus,
   output logic                    bram_en,
   output logic [DATA_WIDTH/8-1:0] bram_write_en,
   output logic [ADDR_WIDTH-1:0]   bram_addr,
   output logic [DATA_WIDTH-1:0]   bram_data_in,
   input  logic [DATA_WIDTH-1:0]   bram_data_out,
   output logic                    busy
);
   localparam int PTR_W = $clog2(RESP_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic                  r_inflight;
   logic                  r_inflight_write;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [DATA_WIDTH:0]   r_fifo [RESP_DEPTH];

   logic                  w_ready;
   logic                  w_fire;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_resp_valid;

   // Credit, issue and FIFO handshake decode; ready depends on registered state only
   always_comb begin
      w_ready       = resetn & ((r_count + CNT_W'(r_inflight)) < CNT_W'(RESP_DEPTH));
      w_fire        = bus.req_valid & w_ready;
      w_push        = r_inflight;
      w_resp_valid  = (r_count != '0);
      w_pop         = w_resp_valid & bus.resp_ready;

      bus.req_ready  = w_ready;
      bram_en        = w_fire;
      bram_write_en  = (w_fire & bus.req_write) ? bus.req_strobe : '0;
      bram_addr      = bus.req_addr;
      bram_data_in   = bus.req_data;

      bus.resp_valid = w_resp_valid;
      bus.resp_write = w_resp_valid ? r_fifo[r_rd_ptr][DATA_WIDTH] : 1'b0;
      bus.resp_data  = w_resp_valid ? r_fifo[r_rd_ptr][DATA_WIDTH-1:0] : '0;
      busy           = r_inflight | w_resp_valid;
   end

   // In-flight tracking, FIFO pointers and occupancy; reset drops everything pending
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_inflight       <= 1'b0;
         r_inflight_write <= 1'b0;
         r_wr_ptr         <= '0;
         r_rd_ptr         <= '0;
         r_count          <= '0;
      end else begin
         r_inflight <= w_fire;
         if (w_fire) r_inflight_write <= bus.req_write;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Response storage: capture the BRAM word the cycle after issue
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= {r_inflight_write, bram_data_out};
   end

   // Requester must hold its request stable while stalled
   a_req_stable: assert property (
      @(posedge clk) disable iff (!resetn)
      (bus.req_valid && !w_ready) |=>
         (bus.req_valid && $stable(bus.req_write) && $stable(bus.req_strobe) &&
          $stable(bus.req_addr) && $stable(bus.req_data))
   );
endmodule

// File: tb/tb_bram_client.sv
// Directed bench for bram_client: a behavioural write_first BRAM, a shadow
// memory that predicts every response at issue time, and an in-order scoreboard.
module tb_bram_client;
   logic        clk = 1'b0;
   logic        resetn;
   logic        bram_en;
   logic [3:0]  bram_write_en;
   logic [3:0]  bram_addr;
   logic [31:0] bram_data_in;
   logic [31:0] bram_data_out;
   logic        busy;

   bram_client_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

   bram_client #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RESP_DEPTH(4)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .bus           (bus),
      .bram_en       (bram_en),
      .bram_write_en (bram_write_en),
      .bram_addr     (bram_addr),
      .bram_data_in  (bram_data_in),
      .bram_data_out (bram_data_out),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   logic [32:0] exp_q [$];
   int          pop_cyc [$];
   logic [31:0] exp_mem [16];
   logic [31:0] bram_mem [16];
   logic [31:0] bram_m;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Behavioural BRAM port, write_first, one-cycle read latency
   always @(posedge clk) begin
      if (bram_en) begin
         bram_m = merge(bram_mem[bram_addr], bram_data_in, bram_write_en);
         bram_mem[bram_addr] <= bram_m;
         bram_data_out       <= bram_m;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: every consumed response is popped and compared in order
   always @(negedge clk) begin
      if (resetn && bus.resp_valid && bus.resp_ready) begin
         if (exp_q.size() == 0) chk("resp_unexpected", 64'(exp_q.size()), 64'd1);
         else begin
            pop_cyc.push_back(cyc);
            chk("resp", {31'd0, bus.resp_write, bus.resp_data}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   // Drive one request and hold it until it fires; prediction is queued at fire
   task automatic issue(input logic w, input logic [3:0] s, input logic [3:0] a,
                        input logic [31:0] d, output int stalls);
      logic [31:0] m;
      bit fired = 0;
      stalls = 0;
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_strobe = s;
      bus.req_addr = a;     bus.req_data = d;
      for (int k = 0; k < 64 && !fired; k++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            fired = 1;
            chk("bram_en", 64'(bram_en), 64'd1);
            chk("bram_we", 64'(bram_write_en), 64'(w ? s : 4'h0));
            chk("bram_addr", 64'(bram_addr), 64'(a));
            m = merge(exp_mem[a], d, w ? s : 4'h0);
            if (w) exp_mem[a] = m;
            exp_q.push_back({w, m});
         end else stalls++;
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      if (!fired) chk("issue_timeout", 64'(stalls), 64'd0);
   endtask

   task automatic wait_idle(input string tag);
      bit done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) done = 1;
      end
      if (!done) chk(tag, 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic expect_head(input string tag, input logic w, input logic [31:0] d);
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.resp_valid) seen = 1;
      end
      chk(tag, {31'd0, bus.resp_write, bus.resp_data}, {31'd0, w, d});
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      int st;
      // Reset with a request pending: nothing may be accepted or issued
      resetn = 1'b0;
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_strobe = 4'hF;
      bus.req_addr = 4'd1;  bus.req_data = 32'hFFFF_FFFF; bus.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_bram_en", 64'(bram_en), 64'd0);
      chk("rst_bram_we", 64'(bram_write_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1; bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("rel_req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;

      // Write then read-after-write on consecutive cycles
      issue(1'b1, 4'hF, 4'd3, 32'h1234_5678, st);
      chk("t2_not_early", 64'(bus.resp_valid), 64'd0);
      issue(1'b0, 4'h0, 4'd3, 32'h0, st);
      @(negedge clk);
      chk("t2_ack", {31'd0, bus.resp_valid, bus.resp_write, bus.resp_data},
          {31'd0, 1'b1, 1'b1, 32'h1234_5678});
      @(negedge clk);
      chk("t2_rd", {31'd0, bus.resp_valid, bus.resp_write, bus.resp_data},
          {31'd0, 1'b1, 1'b0, 32'h1234_5678});
      wait_idle("t2_idle");

      // Byte-masked write and zero-strobe write
      issue(1'b1, 4'hF, 4'd5, 32'h1234_5678, st);
      wait_idle("t3_idle0");
      issue(1'b1, 4'b0010, 4'd5, 32'hAABB_CCDD, st);
      expect_head("t3_ack", 1'b1, 32'h1234_CC78);
      issue(1'b0, 4'h0, 4'd5, 32'h0, st);
      expect_head("t3_rd", 1'b0, 32'h1234_CC78);
      issue(1'b1, 4'h0, 4'd5, 32'hFFFF_FFFF, st);
      expect_head("t3_zero_strobe", 1'b1, 32'h1234_CC78);
      wait_idle("t3_idle1");

      // Preload and back-to-back reads at full rate
      for (int i = 0; i < 8; i++) issue(1'b1, 4'hF, 4'(i), 32'(i * 32'h11), st);
      wait_idle("t4_pre_idle");
      pop_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 4'h0, 4'(i), 32'h0, st);
         chk("t4_no_stall", 64'(st), 64'd0);
      end
      wait_idle("t4_idle");
      chk("t4_resp_count", 64'(pop_cyc.size()), 64'd8);
      for (int i = 1; i < pop_cyc.size(); i++)
         chk("t4_consecutive", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

      // Backpressure: credit allows exactly four outstanding
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 4'h0, 4'(i), 32'h0, st);
         chk("t5_fire", 64'(st), 64'd0);
      end
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_strobe = 4'h0;
      bus.req_addr = 4'd4;  bus.req_data = 32'h0;
      repeat (3) begin
         @(negedge clk);
         chk("t5_full_ready", 64'(bus.req_ready), 64'd0);
         chk("t5_full_busy", 64'(busy), 64'd1);
      end
      @(posedge clk); #1;
      bus.resp_ready = 1'b1;
      issue(1'b0, 4'h0, 4'd4, 32'h0, st);
      wait_idle("t5_idle");

      // Asynchronous reset with two buffered and one in-flight response
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(1'b0, 4'h0, 4'(i), 32'h0, st);
      chk("t6_busy_before", 64'(busy), 64'd1);
      #2 resetn = 1'b0;
      #1;
      chk("t6_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_req_ready", 64'(bus.req_ready), 64'd0);
      chk("t6_resp_data", {31'd0, bus.resp_write, bus.resp_data}, 64'd0);
      exp_q.delete();
      @(posedge clk); #1;
      resetn = 1'b1; bus.resp_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t6_no_stale", 64'(bus.resp_valid), 64'd0);
      end
      @(posedge clk); #1;

      // Operation resumes after reset
      issue(1'b0, 4'h0, 4'd3, 32'h0, st);
      expect_head("t7_rd", 1'b0, 32'h0000_0033);
      wait_idle("t7_idle");
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
